uart_apb_seq: RTL and testbench

APB master sequencer that owns the `apb_uart_sv` register port inside the `uart` peripheral path. After reset it programs the 16550-style register file for 8N1 operation at a fixed divisor. It then moves bytes between a valid/ready stream interface and the UART's THR/RBR registers by polling LSR. CPU-side software never touches the UART registers when this block is instantiated; it sits between a stream producer/consumer and the UART APB slave.

---
 rtl/uart_apb_seq.sv | 218 +++++++++++++++++++++
 tb/tb_uart_apb_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_seq.sv
// APB master sequencer for a 16550-style UART register port.
// After reset it programs the UART for 8N1 at a fixed divisor. It then
// polls LSR and moves bytes between a valid/ready stream pair and
// THR/RBR. RX is served ahead of TX so the UART receive FIFO does not overrun.
module uart_apb_seq #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] DIVISOR    = 16'd100,
  parameter int          TX_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_valid_i,
  input  logic [7:0]            tx_data_i,
  output logic                  tx_ready_o,
  output logic                  rx_valid_o,
  output logic [7:0]            rx_data_o,
  input  logic                  rx_ready_i,
  output logic                  init_done_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           wdata_o,
  output logic                  write_o,
  output logic                  sel_o,
  output logic                  enable_o,
  input  logic [31:0]           rdata_i,
  input  logic                  ready_i
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TX_DEPTH);

  // UART register map (byte addresses on a 32-bit register bus).
  localparam logic [ADDR_WIDTH-1:0] ADDR_RBR_THR = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IER_DLM = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FCR     = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LCR     = ADDR_WIDTH'(32'h0C);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LSR     = ADDR_WIDTH'(32'h14);
  localparam logic [2:0]            LAST_INIT    = 3'd5;

  typedef enum logic [2:0] {
    ST_INIT,    // programming the register file
    ST_POLL,    // reading LSR
    ST_DECIDE,  // idle cycle between transfers, choose next action
    ST_RX_RD,   // reading RBR
    ST_TX_WR    // writing THR
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            data;
  } init_wr_t;

  state_e           state;
  logic [2:0]       init_idx;
  logic             lsr_dr;
  logic             lsr_thre;
  init_wr_t         init_wr;
  logic             access_done;

  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [7:0]       tx_head;

  // Only the low byte of read data carries information from this UART.
  logic             unused_rdata;
  assign unused_rdata = ^rdata_i[31:8];

  assign access_done = sel_o && enable_o && ready_i;
  assign tx_ready_o  = (count != FULL_CNT);
  assign push        = tx_valid_i && tx_ready_o;
  assign pop         = (state == ST_TX_WR) && access_done;
  assign tx_head     = fifo_mem[rd_ptr];

  // Ordered INIT write table: divisor latch open, divisor, 8N1, FIFOs, no IRQs.
  always_comb begin
    // NOTE: default assignment first so every path drives init_wr and no latch is inferred.
    init_wr = '{addr: ADDR_IER_DLM, data: 8'h00};
    case (init_idx)
      3'd0:    init_wr = '{addr: ADDR_LCR,     data: 8'h83};
      3'd1:    init_wr = '{addr: ADDR_RBR_THR, data: DIVISOR[7:0]};
      3'd2:    init_wr = '{addr: ADDR_IER_DLM, data: DIVISOR[15:8]};
      3'd3:    init_wr = '{addr: ADDR_LCR,     data: 8'h03};
      3'd4:    init_wr = '{addr: ADDR_FCR,     data: 8'h07};
      default: init_wr = '{addr: ADDR_IER_DLM, data: 8'h00};
    endcase
  end

  // TX FIFO storage: written on push only.
  // NOTE: the data array is deliberately not reset; emptiness is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= tx_data_i;
  end

  // TX FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM with registered APB and RX stream outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_INIT;
      init_idx    <= '0;
      init_done_o <= 1'b0;
      sel_o       <= 1'b0;
      enable_o    <= 1'b0;
      write_o     <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      rx_valid_o  <= 1'b0;
      rx_data_o   <= '0;
      lsr_dr      <= 1'b0;
      lsr_thre    <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments; a later assignment in this block overrides an earlier one.
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      // Every SETUP cycle is followed by ACCESS.
      if (sel_o && !enable_o) enable_o <= 1'b1;

      case (state)
        ST_INIT: begin
          if (!sel_o) begin
            sel_o   <= 1'b1;
            write_o <= 1'b1;
            addr_o  <= init_wr.addr;
            wdata_o <= {24'h0, init_wr.data};
          end else if (access_done) begin
            sel_o    <= 1'b0;
            enable_o <= 1'b0;
            if (init_idx == LAST_INIT) begin
              init_done_o <= 1'b1;
              state       <= ST_POLL;
            end else begin
              init_idx <= init_idx + 3'd1;
            end
          end
        end

        ST_POLL: begin
          if (!sel_o) begin
            sel_o   <= 1'b1;
            write_o <= 1'b0;
            addr_o  <= ADDR_LSR;
            wdata_o <= '0;
          end else if (access_done) begin
            sel_o    <= 1'b0;
            enable_o <= 1'b0;
            lsr_dr   <= rdata_i[0];
            lsr_thre <= rdata_i[5];
            state    <= ST_DECIDE;
          end
        end

        ST_DECIDE: begin
          // This cycle is the idle gap; the next transfer's SETUP starts at the edge.
          sel_o <= 1'b1;
          if (lsr_dr && !rx_valid_o) begin
            write_o <= 1'b0;
            addr_o  <= ADDR_RBR_THR;
            wdata_o <= '0;
            state   <= ST_RX_RD;
          end else if (lsr_thre && (count != '0)) begin
            write_o <= 1'b1;
            addr_o  <= ADDR_RBR_THR;
            wdata_o <= {24'h0, tx_head};
            state   <= ST_TX_WR;
          end else begin
            write_o <= 1'b0;
            addr_o  <= ADDR_LSR;
            wdata_o <= '0;
            state   <= ST_POLL;
          end
        end

        ST_RX_RD: begin
          if (access_done) begin
            sel_o      <= 1'b0;
            enable_o   <= 1'b0;
            rx_data_o  <= rdata_i[7:0];
            rx_valid_o <= 1'b1;
            state      <= ST_POLL;
          end
        end

        ST_TX_WR: begin
          if (access_done) begin
            sel_o    <= 1'b0;
            enable_o <= 1'b0;
            state    <= ST_POLL;
          end
        end

        default: begin
          sel_o    <= 1'b0;
          enable_o <= 1'b0;
          state    <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_seq.sv
// Self-checking bench for uart_apb_seq: an APB slave model of the UART
// (LSR/RBR/THR with optional wait states) plus scoreboards for APB
// transfers and the RX stream.
module tb_uart_apb_seq;

  localparam int          AW  = 12;
  localparam logic [AW-1:0] LSR = 12'h014;
  localparam logic [AW-1:0] THR = 12'h000;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [31:0]   data;
  } apb_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          tx_valid_i;
  logic [7:0]    tx_data_i;
  logic          tx_ready_o;
  logic          rx_valid_o;
  logic [7:0]    rx_data_o;
  logic          rx_ready_i;
  logic          init_done_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic          write_o;
  logic          sel_o;
  logic          enable_o;
  logic [31:0]   rdata_i;
  logic          ready_i;

  uart_apb_seq #(.ADDR_WIDTH(AW), .DIVISOR(16'd100), .TX_DEPTH(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .tx_valid_i  (tx_valid_i),
    .tx_data_i   (tx_data_i),
    .tx_ready_o  (tx_ready_o),
    .rx_valid_o  (rx_valid_o),
    .rx_data_o   (rx_data_o),
    .rx_ready_i  (rx_ready_i),
    .init_done_o (init_done_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .write_o     (write_o),
    .sel_o       (sel_o),
    .enable_o    (enable_o),
    .rdata_i     (rdata_i),
    .ready_i     (ready_i)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  apb_t       exp_apb_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] uart_rx_q[$];   // bytes waiting inside the modelled UART
  bit         thre_en   = 1'b1;
  bit         stall_thr = 1'b0;
  int         max_wait  = 0;

  // Slave-side tracking.
  int            cyc = 0;
  int            idle_run = 0;
  bit            seen_xfer = 1'b0;
  int            init_writes = 0;
  bit            done_due = 1'b0;
  int            wait_left = 0;
  int            t_poll = 0;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic          s_write;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected INIT programming for 8N1 with divisor 100.
  function automatic void push_init();
    exp_apb_q.push_back('{addr: 12'h00C, write: 1'b1, data: 32'h83});
    exp_apb_q.push_back('{addr: 12'h000, write: 1'b1, data: 32'h64});
    exp_apb_q.push_back('{addr: 12'h004, write: 1'b1, data: 32'h00});
    exp_apb_q.push_back('{addr: 12'h00C, write: 1'b1, data: 32'h03});
    exp_apb_q.push_back('{addr: 12'h008, write: 1'b1, data: 32'h07});
    exp_apb_q.push_back('{addr: 12'h004, write: 1'b1, data: 32'h00});
  endfunction

  // UART read data: LSR exposes DR/THRE over random noise, RBR the head byte.
  function automatic logic [31:0] model_rdata();
    logic [31:0] r;
    r = $urandom;
    if (addr_o == LSR) begin
      r[0] = (uart_rx_q.size() != 0);
      r[5] = thre_en;
    end else if (uart_rx_q.size() != 0) begin
      r[7:0] = uart_rx_q[0];
    end
    return r;
  endfunction

  // APB slave model and transfer monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      idle_run    = 0;
      seen_xfer   = 1'b0;
      init_writes = 0;
      done_due    = 1'b0;
      ready_i     = 1'b0;
    end else begin
      if (done_due) begin
        check("init_done_rise", {31'h0, init_done_o}, 32'h1);
        done_due = 1'b0;
      end
      if (!sel_o) begin
        idle_run++;
        ready_i = 1'b0;
      end else if (!enable_o) begin
        if (seen_xfer) check("idle_gap", idle_run, 1);
        idle_run  = 0;
        seen_xfer = 1'b1;
        s_addr    = addr_o;
        s_wdata   = wdata_o;
        s_write   = write_o;
        wait_left = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
        if (!write_o && addr_o == LSR) t_poll = cyc;
        ready_i   = 1'b0;
        rdata_i   = model_rdata();
      end else begin
        rdata_i = model_rdata();
        if (stall_thr && init_writes >= 6 && write_o && addr_o == THR) begin
          ready_i = 1'b0;
        end else if (wait_left > 0) begin
          ready_i = 1'b0;
          wait_left--;
        end else begin
          ready_i = 1'b1;
          check("access_stable_ctl", {19'h0, write_o, addr_o}, {19'h0, s_write, s_addr});
          check("access_stable_wdata", wdata_o, s_wdata);
          if (!(!write_o && addr_o == LSR)) begin
            if (exp_apb_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_xfer: got addr 0x%0h write %0b wdata 0x%0h, expected no transfer",
                       addr_o, write_o, wdata_o);
            end else begin
              apb_t e;
              e = exp_apb_q.pop_front();
              check("xfer_addr_write", {19'h0, write_o, addr_o}, {19'h0, e.write, e.addr});
              if (e.write) check("xfer_wdata", wdata_o, e.data);
            end
          end
          if (init_writes < 6) begin
            if (write_o) begin
              check("init_done_low", {31'h0, init_done_o}, 32'h0);
              init_writes++;
              if (init_writes == 6) done_due = 1'b1;
            end
          end else if (!(!write_o && addr_o == LSR)) begin
            if (!write_o) begin
              check("rbr_while_rx_valid", {31'h0, rx_valid_o}, 32'h0);
              if (uart_rx_q.size() != 0) void'(uart_rx_q.pop_front());
            end
            if (max_wait == 0) check("poll_to_xfer_cycles", 32'(cyc - t_poll), 32'd4);
          end
        end
      end
    end
  end

  // RX stream monitor.
  always @(negedge clk) begin
    if (rstn && rx_valid_o && rx_ready_i) begin
      if (exp_rx_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rx: got 0x%0h, expected no byte", rx_data_o);
      end else begin
        check("rx_data", {24'h0, rx_data_o}, {24'h0, exp_rx_q.pop_front()});
      end
    end
  end

  task automatic check_reset_values();
    check("rst_sel_en_wr", {29'h0, sel_o, enable_o, write_o}, 32'h0);
    check("rst_addr", {20'h0, addr_o}, 32'h0);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_rx", {23'h0, rx_valid_o, rx_data_o}, 32'h0);
    check("rst_init_done", {31'h0, init_done_o}, 32'h0);
    check("rst_tx_ready", {31'h0, tx_ready_o}, 32'h1);
  endtask

  task automatic wait_init(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (init_done_o) break;
    end
    check(name, {31'h0, init_done_o}, 32'h1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_apb_q.size() == 0) break;
    end
    check(name, exp_apb_q.size(), 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    tx_valid_i = 1'b1;
    tx_data_i  = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_ready_o) begin
        exp_apb_q.push_back('{addr: THR, write: 1'b1, data: {24'h0, b}});
        @(posedge clk);
        #1;
        tx_valid_i = 1'b0;
        return;
      end
    end
    check("push_timeout", {31'h0, tx_ready_o}, 32'h1);
    tx_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    exp_apb_q.delete();
    push_init();
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b5;
    rstn       = 1'b0;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    rx_ready_i = 1'b0;
    rdata_i    = 32'h0;
    ready_i    = 1'b0;

    // Reset values and zero-wait INIT sequence.
    repeat (3) @(negedge clk);
    check_reset_values();
    push_init();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_init("init_done_timeout");
    repeat (5) @(negedge clk);
    check("init_all_seen", exp_apb_q.size(), 0);

    // TX with THRE=1, DR=0.
    thre_en = 1'b1;
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    @(negedge clk);
    check("tx_ready_light_load", {31'h0, tx_ready_o}, 32'h1);
    wait_drain("tx_drain_abc");

    // RX with backpressure.
    thre_en = 1'b0;
    @(posedge clk);
    #1;
    uart_rx_q.push_back(8'h5A);
    uart_rx_q.push_back(8'h77);
    exp_rx_q.push_back(8'h5A);
    exp_rx_q.push_back(8'h77);
    exp_apb_q.push_back('{addr: THR, write: 1'b0, data: 32'h0});
    exp_apb_q.push_back('{addr: THR, write: 1'b0, data: 32'h0});
    repeat (40) @(negedge clk);
    check("rx_valid_held", {31'h0, rx_valid_o}, 32'h1);
    check("rx_data_first", {24'h0, rx_data_o}, 32'h5A);
    check("rbr_left_in_uart", uart_rx_q.size(), 1);
    @(posedge clk);
    #1;
    rx_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rx_ready_i = 1'b0;
    @(negedge clk);
    check("rx_valid_clear", {31'h0, rx_valid_o}, 32'h0);
    repeat (40) @(negedge clk);
    check("rx_data_second", {24'h0, rx_data_o}, 32'h77);
    check("rx_valid_second", {31'h0, rx_valid_o}, 32'h1);
    check("rbr_all_read", uart_rx_q.size(), 0);
    @(posedge clk);
    #1;
    rx_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    check("rx_drained", exp_rx_q.size(), 0);
    check("rx_idle", {31'h0, rx_valid_o}, 32'h0);

    // Full FIFO with THRE=0, fifth byte held off, then drain in order.
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(255, 0)));
    @(negedge clk);
    check("tx_ready_full", {31'h0, tx_ready_o}, 32'h0);
    b5 = 8'($urandom_range(255, 0));
    @(posedge clk);
    #1;
    tx_valid_i = 1'b1;
    tx_data_i  = b5;
    repeat (10) @(negedge clk);
    check("tx_ready_held_off", {31'h0, tx_ready_o}, 32'h0);
    check("no_thr_while_busy", exp_apb_q.size(), 4);
    thre_en = 1'b1;
    push_byte(b5);
    wait_drain("tx_drain_full");

    // Random wait states through INIT and TX.
    max_wait = 3;
    do_reset();
    wait_init("init_done_wait_timeout");
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(255, 0)));
    wait_drain("tx_drain_wait");

    // Reset during the ACCESS phase of a THR write.
    stall_thr = 1'b1;
    push_byte(8'hA1);
    push_byte(8'hA2);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sel_o && enable_o && write_o && addr_o == THR && init_done_o) break;
    end
    check("thr_access_reached", {30'h0, sel_o, enable_o}, 32'h3);
    #2;
    rstn = 1'b0;
    #1;
    check("async_drop_sel_en", {30'h0, sel_o, enable_o}, 32'h0);
    stall_thr = 1'b0;
    exp_apb_q.delete();
    push_init();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_init("init_done_reinit_timeout");
    repeat (60) @(negedge clk);
    check("reinit_no_stale", exp_apb_q.size(), 0);
    check("reinit_tx_ready", {31'h0, tx_ready_o}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
